// File: rtl/seg_scan_scheduler.sv
// Scan controller for an 8-digit 7-segment display: blank gap before every digit, with all
// counter values latched once per frame so one frame never mixes old and new counts.
module seg_scan_scheduler #(
    parameter int unsigned DIGIT_CYCLES = 250,
    parameter int unsigned BLANK_CYCLES = 10,
    parameter logic [7:0]  DIGIT_EN     = 8'b0011_1111
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] PB_high,
    input  logic [7:0] PB_std,
    input  logic [7:0] PB_low,
    output logic [6:0] segments,
    output logic [7:0] anodos,
    output logic [2:0] digit_idx,
    output logic       frame_start
);

    localparam int unsigned MaxCycles = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES
                                                                      : BLANK_CYCLES;
    localparam int unsigned CntW = $clog2(MaxCycles + 1);

    typedef enum logic {StBlank, StOn} state_e;

    state_e          r_state, w_state_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic [2:0]      r_idx, w_idx_d;
    logic [7:0]      r_snap_high, r_snap_std, r_snap_low;
    logic [7:0]      w_snap_high_d, w_snap_std_d, w_snap_low_d;
    logic [6:0]      r_segments, w_segments_d;
    logic [7:0]      r_anodos, w_anodos_d;
    logic            r_frame_start;
    logic            w_take;
    logic [3:0]      w_nibble;
    logic            w_dark_digit;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt + CntW'(1);
        w_idx_d   = r_idx;
        if (r_state == StBlank) begin
            if (r_cnt == CntW'(BLANK_CYCLES - 1)) begin
                w_state_d = StOn;
                w_cnt_d   = '0;
            end
        end else if (r_cnt == CntW'(DIGIT_CYCLES - 1)) begin
            w_state_d = StBlank;
            w_cnt_d   = '0;
            w_idx_d   = r_idx + 3'd1;
        end
    end

    assign w_take        = (r_state == StBlank) && (r_idx == 3'd0) && (r_cnt == '0);
    assign w_snap_high_d = w_take ? PB_high : r_snap_high;
    assign w_snap_std_d  = w_take ? PB_std  : r_snap_std;
    assign w_snap_low_d  = w_take ? PB_low  : r_snap_low;

    // Outputs are decoded from next-state (and next snapshot, for BLANK_CYCLES == 1) so they
    // are valid in the very cycle a state is entered.
    always_comb begin
        w_nibble     = 4'h0;
        w_dark_digit = 1'b0;
        unique case (w_idx_d)
            3'd0: w_nibble = w_snap_low_d[3:0];
            3'd1: w_nibble = w_snap_low_d[7:4];
            3'd2: w_nibble = w_snap_std_d[3:0];
            3'd3: w_nibble = w_snap_std_d[7:4];
            3'd4: w_nibble = w_snap_high_d[3:0];
            3'd5: w_nibble = w_snap_high_d[7:4];
            default: w_dark_digit = 1'b1;
        endcase
        w_segments_d = 7'h7F;
        w_anodos_d   = 8'hFF;
        if (w_state_d == StOn) begin
            if (!w_dark_digit) w_segments_d = hex7(w_nibble);
            if (DIGIT_EN[w_idx_d]) w_anodos_d = ~(8'd1 << w_idx_d);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= StBlank;
            r_cnt         <= '0;
            r_idx         <= 3'd0;
            r_snap_high   <= 8'h00;
            r_snap_std    <= 8'h00;
            r_snap_low    <= 8'h00;
            r_segments    <= 7'h7F;
            r_anodos      <= 8'hFF;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_cnt         <= w_cnt_d;
            r_idx         <= w_idx_d;
            r_snap_high   <= w_snap_high_d;
            r_snap_std    <= w_snap_std_d;
            r_snap_low    <= w_snap_low_d;
            r_segments    <= w_segments_d;
            r_anodos      <= w_anodos_d;
            r_frame_start <= w_take;
        end
    end

    assign segments    = r_segments;
    assign anodos      = r_anodos;
    assign digit_idx   = r_idx;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed bench for seg_scan_scheduler with DIGIT_CYCLES=4, BLANK_CYCLES=2; a second
// instance has every digit enabled to exercise the dark slots 6 and 7.
module tb_seg_scan_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pb_high = 8'h00, pb_std = 8'h00, pb_low = 8'h00;
    logic [6:0] seg1, seg2;
    logic [7:0] an1, an2;
    logic [2:0] idx1, idx2;
    logic       fs1, fs2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    seg_scan_scheduler #(.DIGIT_CYCLES(4), .BLANK_CYCLES(2)) u_dut (
        .clock(clock), .reset(reset), .PB_high(pb_high), .PB_std(pb_std), .PB_low(pb_low),
        .segments(seg1), .anodos(an1), .digit_idx(idx1), .frame_start(fs1)
    );

    seg_scan_scheduler #(.DIGIT_CYCLES(4), .BLANK_CYCLES(2), .DIGIT_EN(8'hFF)) u_dut_all (
        .clock(clock), .reset(reset), .PB_high(pb_high), .PB_std(pb_std), .PB_low(pb_low),
        .segments(seg2), .anodos(an2), .digit_idx(idx2), .frame_start(fs2)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic go_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        pb_low = 8'hA5; pb_std = 8'h12; pb_high = 8'hC3;
        repeat (3) tick();
        checks++;
        if ({an1, seg1, idx1, fs1} !== {8'hFF, 7'h7F, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got an=%h seg=%b idx=%0d fs=%b want an=ff seg=1111111 idx=0 fs=0",
                     an1, seg1, idx1, fs1);
        end
        reset = 1'b0;
        cyc   = 0;
        checks++;
        if (fs1 !== 1'b0) begin
            errors++;
            $display("FAIL fs_cycle0 got %b want 0", fs1);
        end
        tick();
        checks++;
        if ({an1, seg1, idx1, fs1} !== {8'hFF, 7'h7F, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL fs_cycle1 got an=%h seg=%b idx=%0d fs=%b want an=ff seg=1111111 idx=0 fs=1",
                     an1, seg1, idx1, fs1);
        end
    endtask

    task automatic test_digit_timing();
        for (int c = 2; c <= 11; c++) begin
            logic [17:0] exp;
            go_to(c);
            if (c <= 5)      exp = {8'hFE, 7'b0100100, 3'd1};
            else if (c <= 7) exp = {8'hFF, 7'h7F, 3'd1};
            else             exp = {8'hFD, 7'b0001000, 3'd1};
            if (c <= 5) exp[2:0] = 3'd0;
            checks++;
            if ({an1, seg1, idx1} !== exp) begin
                errors++;
                $display("FAIL digit_timing c%0d got an=%h seg=%b idx=%0d want an=%h seg=%b idx=%0d",
                         c, an1, seg1, idx1, exp[17:10], exp[9:3], exp[2:0]);
            end
        end
    endtask

    task automatic test_snapshot();
        go_to(14);
        checks++;
        if ({an1, seg1, idx1} !== {8'hFB, 7'b0010010, 3'd2}) begin
            errors++;
            $display("FAIL snap_d2 got an=%h seg=%b idx=%0d want an=fb seg=0010010 idx=2",
                     an1, seg1, idx1);
        end
        pb_std = 8'h34;
        go_to(20);
        checks++;
        if ({an1, seg1, idx1} !== {8'hF7, 7'b1001111, 3'd3}) begin
            errors++;
            $display("FAIL snap_d3 got an=%h seg=%b idx=%0d want an=f7 seg=1001111 idx=3",
                     an1, seg1, idx1);
        end
        go_to(26);
        checks++;
        if ({an1, seg1, idx1} !== {8'hEF, 7'b0000110, 3'd4}) begin
            errors++;
            $display("FAIL snap_d4 got an=%h seg=%b idx=%0d want an=ef seg=0000110 idx=4",
                     an1, seg1, idx1);
        end
        go_to(32);
        checks++;
        if ({an1, seg1, idx1} !== {8'hDF, 7'b0110001, 3'd5}) begin
            errors++;
            $display("FAIL snap_d5 got an=%h seg=%b idx=%0d want an=df seg=0110001 idx=5",
                     an1, seg1, idx1);
        end
    endtask

    task automatic test_dark_digits();
        for (int c = 36; c <= 47; c++) begin
            go_to(c);
            checks++;
            if ({an1, seg1} !== {8'hFF, 7'h7F}) begin
                errors++;
                $display("FAIL dark_slot c%0d got an=%h seg=%b want an=ff seg=1111111",
                         c, an1, seg1);
            end
            if (c == 38 || c == 44) begin
                checks++;
                if ({an2, seg2} !== {(c == 38) ? 8'hBF : 8'h7F, 7'h7F}) begin
                    errors++;
                    $display("FAIL all_en_slot c%0d got an=%h seg=%b want an=%h seg=1111111",
                             c, an2, seg2, (c == 38) ? 8'hBF : 8'h7F);
                end
            end
        end
    endtask

    task automatic test_frame_repeat();
        go_to(48);
        checks++;
        if ({fs1, idx1, an1} !== {1'b0, 3'd0, 8'hFF}) begin
            errors++;
            $display("FAIL frame_c48 got fs=%b idx=%0d an=%h want fs=0 idx=0 an=ff", fs1, idx1, an1);
        end
        go_to(49);
        checks++;
        if (fs1 !== 1'b1) begin
            errors++;
            $display("FAIL frame_c49 got fs=%b want 1", fs1);
        end
        go_to(50);
        checks++;
        if ({fs1, an1, seg1} !== {1'b0, 8'hFE, 7'b0100100}) begin
            errors++;
            $display("FAIL frame_c50 got fs=%b an=%h seg=%b want fs=0 an=fe seg=0100100",
                     fs1, an1, seg1);
        end
        go_to(62);
        checks++;
        if ({an1, seg1} !== {8'hFB, 7'b1001100}) begin
            errors++;
            $display("FAIL new_std_d2 got an=%h seg=%b want an=fb seg=1001100", an1, seg1);
        end
        go_to(68);
        checks++;
        if ({an1, seg1} !== {8'hF7, 7'b0000110}) begin
            errors++;
            $display("FAIL new_std_d3 got an=%h seg=%b want an=f7 seg=0000110", an1, seg1);
        end
    endtask

    task automatic test_reset_mid_on();
        go_to(69);
        reset  = 1'b1;
        pb_low = 8'h0E;
        tick();
        checks++;
        if ({an1, seg1, idx1, fs1, an2, idx2} !== {8'hFF, 7'h7F, 3'd0, 1'b0, 8'hFF, 3'd0}) begin
            errors++;
            $display("FAIL mid_on_reset got an=%h seg=%b idx=%0d fs=%b an2=%h idx2=%0d want ff/7f/0/0",
                     an1, seg1, idx1, fs1, an2, idx2);
        end
        reset = 1'b0;
        cyc   = 0;
        tick();
        checks++;
        if ({fs1, an1} !== {1'b1, 8'hFF}) begin
            errors++;
            $display("FAIL restart_c1 got fs=%b an=%h want fs=1 an=ff", fs1, an1);
        end
        tick();
        checks++;
        if ({an1, seg1, idx1, fs1} !== {8'hFE, 7'b0110000, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL restart_c2 got an=%h seg=%b idx=%0d fs=%b want an=fe seg=0110000 idx=0 fs=0",
                     an1, seg1, idx1, fs1);
        end
    endtask

    task automatic test_random_invariants();
        int on_run  = 0;
        int off_run = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cyc   = 0;
        for (int n = 0; n < 960; n++) begin
            checks++;
            if ($countones(~an1) > 1 || $countones(~an2) > 1) begin
                errors++;
                $display("FAIL one_hot_anode c%0d got an=%h an2=%h want at most one low bit",
                         n, an1, an2);
            end
            if (an2 != 8'hFF) begin
                if (on_run == 0) begin
                    checks++;
                    if (off_run < 2) begin
                        errors++;
                        $display("FAIL blank_gap c%0d got %0d want >=2", n, off_run);
                    end
                end
                checks++;
                if (an2 !== ~(8'd1 << idx2)) begin
                    errors++;
                    $display("FAIL anode_idx c%0d got an=%h idx=%0d want an=%h",
                             n, an2, idx2, ~(8'd1 << idx2));
                end
                on_run++;
                off_run = 0;
            end else begin
                if (on_run > 0) begin
                    checks++;
                    if (on_run != 4) begin
                        errors++;
                        $display("FAIL on_run c%0d got %0d want 4", n, on_run);
                    end
                end
                on_run = 0;
                off_run++;
            end
            pb_high = 8'($urandom);
            pb_std  = 8'($urandom);
            pb_low  = 8'($urandom);
            tick();
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_digit_timing();
        test_snapshot();
        test_dark_digits();
        test_frame_repeat();
        test_reset_mid_on();
        test_random_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
